// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-read-port datapath register file.
// Entry 0 is hardwired to zero. After reset a hardware sweep writes 0 to every
// entry (init_busy high meanwhile); reads are registered with one-cycle latency.
// Optional feature macro: RF_BYPASS_EN. When defined, a read of the address being
// written in the same cycle returns the new data (write-first). When undefined,
// it returns the old entry value (read-first).
module reg_file_mp #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic                       wr_en,
    input  logic                       wr_dst_sel,
    input  logic [ADDR_W-1:0]          wr_addr_a,
    input  logic [ADDR_W-1:0]          wr_addr_b,
    input  logic                       mem_to_reg,
    input  logic [DATA_W-1:0]          wr_data_alu,
    input  logic [DATA_W-1:0]          wr_data_mem,
    output logic                       init_busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                      state_r;
    state_t                      state_next_s;
    logic [ADDR_W-1:0]           clear_ptr_r;
    logic [ADDR_W-1:0]           clear_ptr_next_s;
    logic                        init_busy_r;
    logic [DATA_W-1:0]           mem_r [DEPTH];
    logic [ADDR_W-1:0]           waddr_s;
    logic [DATA_W-1:0]           wdata_s;
    logic                        we_s;
    logic [NUM_RD*DATA_W-1:0]    rd_next_s;
    logic [NUM_RD*DATA_W-1:0]    rd_data_r;

    // Sweep control: advance the clear pointer and leave CLEAR after the last entry.
    always_comb begin
        state_next_s     = state_r;
        clear_ptr_next_s = clear_ptr_r;
        case (state_r)
            ST_CLEAR: begin
                clear_ptr_next_s = clear_ptr_r + ADDR_W'(1);
                if (clear_ptr_r == LAST_PTR) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_CLEAR;
                end
            end
            ST_RUN: begin
                state_next_s = ST_RUN;
            end
            default: begin
                state_next_s     = ST_CLEAR;
                clear_ptr_next_s = ZERO_ADDR;
            end
        endcase
    end

    // State, sweep pointer and busy flag registers; reset restarts the sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_CLEAR;
            clear_ptr_r <= ZERO_ADDR;
            init_busy_r <= 1'b1;
        end else begin
            state_r     <= state_next_s;
            clear_ptr_r <= clear_ptr_next_s;
            init_busy_r <= (state_next_s == ST_CLEAR);
        end
    end

    // Write port selection; writes only in RUN and never to entry 0.
    always_comb begin
        waddr_s = ZERO_ADDR;
        wdata_s = {DATA_W{1'b0}};
        we_s    = 1'b0;
        if (wr_dst_sel) begin
            waddr_s = wr_addr_a;
        end else begin
            waddr_s = wr_addr_b;
        end
        if (mem_to_reg) begin
            wdata_s = wr_data_mem;
        end else begin
            wdata_s = wr_data_alu;
        end
        if ((state_r == ST_RUN) && wr_en && (waddr_s != ZERO_ADDR)) begin
            we_s = 1'b1;
        end else begin
            we_s = 1'b0;
        end
    end

    // Storage array: the sweep zeroes one entry per cycle, otherwise take writes.
    always_ff @(posedge clk) begin
        if (state_r == ST_CLEAR) begin
            mem_r[clear_ptr_r] <= {DATA_W{1'b0}};
        end else if (we_s) begin
            mem_r[waddr_s] <= wdata_s;
        end
    end

    // Next read data per port: zero while sweeping or for address 0.
    always_comb begin
        rd_next_s = {(NUM_RD*DATA_W){1'b0}};
        for (int i = 0; i < NUM_RD; i++) begin
            if (state_r != ST_RUN) begin
                rd_next_s[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
            end else if (rd_addr[i*ADDR_W +: ADDR_W] == ZERO_ADDR) begin
                rd_next_s[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
`ifdef RF_BYPASS_EN
            end else if (we_s && (rd_addr[i*ADDR_W +: ADDR_W] == waddr_s)) begin
                rd_next_s[i*DATA_W +: DATA_W] = wdata_s;
`endif
            end else begin
                rd_next_s[i*DATA_W +: DATA_W] = mem_r[rd_addr[i*ADDR_W +: ADDR_W]];
            end
        end
    end

    // Registered read ports.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_r <= {(NUM_RD*DATA_W){1'b0}};
        end else begin
            rd_data_r <= rd_next_s;
        end
    end

    assign rd_data   = rd_data_r;
    assign init_busy = init_busy_r;

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-read-port register file; successor to the fixed 16x16, five-read-port datapath register file.
- Generalised in data width, depth and read-port count.
- Adds hardware clear-on-reset sweep with busy flag, hardwired-zero entry 0, registered reads, and an optional write-to-read bypass.
- Sits between decode (read addresses) and writeback (ALU/MDR result) in the processor datapath.

Parameters:
- DATA_W, 16, width of each entry and of all data ports.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 5, number of independent read ports.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port i = bits [i*ADDR_W +: ADDR_W].
- rd_data  output  NUM_RD*DATA_W  packed registered read data; port i = bits [i*DATA_W +: DATA_W].
- wr_en  input  1  write enable.
- wr_dst_sel  input  1  1 selects wr_addr_a, 0 selects wr_addr_b.
- wr_addr_a  input  ADDR_W  write address, R-type/branch destination.
- wr_addr_b  input  ADDR_W  write address, load/store register field.
- mem_to_reg  input  1  1 selects wr_data_mem, 0 selects wr_data_alu.
- wr_data_alu  input  DATA_W  ALU result.
- wr_data_mem  input  DATA_W  memory data register result.
- init_busy  output  1  high while the clear sweep runs.

Behaviour:
- Reset (rst=1, asynchronous):
  - state=CLEAR, clear_ptr=0.
  - init_busy=1.
  - all rd_data=0.
  - Array contents are not touched asynchronously.
- FSM states: CLEAR, RUN.
- CLEAR:
  - Each cycle writes 0 to entry clear_ptr, then clear_ptr+1.
  - After the write of entry DEPTH-1: next state RUN, init_busy=0 from the following cycle.
  - Duration is exactly DEPTH cycles after rst deasserts.
  - wr_en is ignored in this state.
  - All rd_data are registered as 0 in this state.
- RUN: no exit except rst.
- Reset asserted mid-sweep: the sweep restarts from entry 0 and takes the full DEPTH cycles again.
- Write path (RUN only):
  - waddr = wr_dst_sel ? wr_addr_a : wr_addr_b.
  - wdata = mem_to_reg ? wr_data_mem : wr_data_alu.
  - On a rising edge with wr_en=1, entry waddr <= wdata.
  - A write to waddr=0 is discarded; entry 0 always reads 0.
- Read path:
  - Each port is registered with 1-cycle latency: rd_data[i] at edge n+1 = entry(rd_addr[i]) as sampled at edge n.
  - Ports are independent; any number may address the same entry.
- Simultaneous read and write to the same nonzero address in one cycle:
  - Behaviour is set by the optional feature below.
  - Reads from address 0 always return 0 regardless of any write.
- No X on outputs after reset, including entries never written by software (the sweep guarantees this).

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: if wr_en=1 in RUN, rd_addr[i]==waddr and waddr!=0, then rd_data[i] captures wdata on that edge (write-first forwarding).
- Undefined: rd_data[i] captures the old entry value (read-first); the new value is visible from the next read.

Test Plan:
1. Reset then deassert; hold rd_addr all =3 -> init_busy=1 for exactly 16 cycles, then 0; every rd_data=0 throughout and after.
2. RUN: write 0xBEEF to address 5 (wr_dst_sel=1, wr_addr_a=5, mem_to_reg=0, wr_data_alu=0xBEEF); next cycle read port 2 at 5 -> rd_data port 2 = 0xBEEF one edge later.
3. Write 0x1234 to address 0 via wr_addr_b with mem_to_reg=1 -> all ports reading 0 return 0x0000.
4. Address 7 holds 0x0011; write 0x00AA to 7 while port 0 reads 7 in the same cycle -> rd_data port 0 = 0x00AA with RF_BYPASS_EN, 0x0011 without; next read = 0x00AA in both builds.
5. Pulse rst for 1 cycle at sweep cycle 8, with wr_en=1 attempted during the sweep -> init_busy stays high for 16 further cycles, and entries written before the reset read 0 afterwards.
6. All 5 ports read distinct addresses 1,2,3,4,5 preloaded with 0x0101..0x0505 -> each port returns its value with 1-cycle latency, no cross-port interference.
